rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Writeback arbiter and scoreboard for the 64-bit, 32-entry integer register file: shares its single write port between the ALU and memory (load) writeback pipes. It also tracks which architectural registers have an in-flight producer, so that decode can stall on RAW/WAW hazards. Sits between the execute/memory stages and the register file write port; the busy outputs feed the decode stall logic.

## Interface
- XLEN, 64, data width of register values
- AW, 5, register address width (2**AW registers; register 0 hard-wired zero)

- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- alu_valid  input  1  ALU pipe has a result to write
- alu_ready  output  1  ALU result accepted this cycle
- alu_rd  input  AW  ALU destination register
- alu_data  input  XLEN  ALU result
- mem_valid  input  1  load pipe has a result to write
- mem_ready  output  1  load result accepted this cycle
- mem_rd  input  AW  load destination register
- mem_data  input  XLEN  load result
- sb_set  input  1  decode issues an instruction writing sb_set_rd
- sb_set_rd  input  AW  destination of the issuing instruction
- rs1_q, rs2_q, rd_q  input  AW each  decode query addresses
- rs1_busy, rs2_busy, rd_busy  output  1 each  queried register has a pending producer
- rf_we  output  1  register file write enable (registered)
- rf_waddr  output  AW  register file write address (registered)
- rf_wdata  output  XLEN  register file write data (registered)

## Operation
- Arbitration (combinational): at most one of alu_ready / mem_ready is high per cycle; ready = grant. A requester with valid low is never granted.
- Single requester valid: that requester is granted.
- Both valid: the Configuration rule picks the winner; the loser holds valid, rd and data stable until granted. Data changing while valid and not ready is a protocol violation.
- Grant with rd != 0: the next cycle drives rf_we=1, rf_waddr=rd, rf_wdata=data.
- Grant with rd == 0: the request is consumed (ready high), rf_we=0 next cycle, and no scoreboard effect.
- No grant: rf_we=0 next cycle; rf_waddr/rf_wdata hold their previous values.
- Scoreboard: a 32-bit pending vector.
  - sb_set with sb_set_rd != 0 sets pending[sb_set_rd] at the clock edge.
  - A cycle with rf_we=1 clears pending[rf_waddr] at the clock edge.
  - Set and clear of the same register in the same cycle: set wins.
  - pending[0] is constant 0.
- Busy outputs (combinational): x_busy = pending[x_q] & ~(rf_we & rf_waddr == x_q) & (x_q != 0).
  - The register being written this cycle reads as not busy, because the register file bypasses wdata on a same-cycle read.
- Decode contract: never assert sb_set for a register whose rd_busy is high, so there is at most one producer per register. A violation is not detected.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, RR pointer favours mem.
- Reset asserted mid-operation: all of the above state is cleared at the edge, and any in-flight grant is dropped. alu_ready and mem_ready are forced 0 while rst_n=0.
- Latency: grant in cycle N -> rf_we in cycle N+1 -> pending cleared at the end of N+1.
- Busy drops: combinationally in N+1.
- Throughput: one write per cycle; the write port never back-pressures the arbiter.

## Configuration
- WB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant pointer updates on every grant where both requesters were valid.
  - On conflict, the requester not granted last conflict wins; the first conflict after reset goes to mem.
- WB_RR_EN undefined: fixed priority, mem over alu; no pointer flop exists.

## Test plan
- Reset: hold rst_n=0 with both valid -> both ready=0; after release rf_we=0, rf_waddr=0, and rs1_busy=0 for every query.
- Single write: sb_set rd=5, then alu_valid rd=5 data=0x1234 -> alu_ready same cycle; next cycle rf_we=1, waddr=5, wdata=0x1234, rs1_busy(5)=0; pending[5]=0 afterwards.
- Conflict, three cycles with both valid:
  - WB_RR_EN undefined: grants mem, mem, mem, with alu starved while mem stays valid.
  - WB_RR_EN defined: grants mem, alu, mem.
- x0 write: mem_valid rd=0 data=0xFFFF -> mem_ready=1; rf_we=0 next cycle; rs1_busy(0)=0 throughout.
- Set/clear same cycle: write to rd=7 in flight (rf_we=1, waddr=7) while sb_set rd=7 -> rd_busy(7)=1 the following cycle.
- Reset mid-operation: pending={3,9}, alu granted rd=3, rst_n=0 next edge -> rf_we=0 and all busy outputs 0 after reset.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the single register-file write port between the ALU and load
//   writeback pipes. It also keeps a pending-producer scoreboard so that
//   decode can stall on RAW/WAW hazards.
//
//   Optional feature macro: WB_RR_EN
//     defined   -> round-robin arbitration on conflict (the first conflict
//                  after reset goes to mem)
//     undefined -> fixed priority, mem over alu (no pointer flop)
//
//   Ports
//     clk, rst_n                    clock, synchronous active-low reset
//     alu_valid/ready/rd/data       ALU writeback request (ready = grant)
//     mem_valid/ready/rd/data       load writeback request (ready = grant)
//     sb_set, sb_set_rd             decode marks a destination as pending
//     rs1_q, rs2_q, rd_q            decode hazard query addresses
//     rs1_busy, rs2_busy, rd_busy   queried register has a pending producer
//     rf_we, rf_waddr, rf_wdata     registered register-file write port
`timescale 1ns/1ps
module rf_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_set_rd,
  input  logic [AW-1:0]   rs1_q,
  input  logic [AW-1:0]   rs2_q,
  input  logic [AW-1:0]   rd_q,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_busy,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;
  logic            w_mem_wins;
  logic            w_gnt_alu;
  logic            w_gnt_mem;
  logic [AW-1:0]   w_wrd;
  logic [XLEN-1:0] w_wdata;
  logic            w_wr;

`ifdef WB_RR_EN
  // Remembers who won the last conflict; reset value makes mem win the
  // first conflict. Only conflicts move the pointer.
  logic r_alu_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_last <= 1'b1;
    end else if (alu_valid && mem_valid) begin
      r_alu_last <= w_gnt_alu;
    end
  end

  assign w_mem_wins = r_alu_last;
`else
  assign w_mem_wins = 1'b1;
`endif

  // Grants are suppressed while reset is asserted so no request is consumed
  // and then dropped by the reset edge.
  always_comb begin
    w_gnt_alu = 1'b0;
    w_gnt_mem = 1'b0;
    if (rst_n) begin
      if (mem_valid && (!alu_valid || w_mem_wins)) begin
        w_gnt_mem = 1'b1;
      end else if (alu_valid) begin
        w_gnt_alu = 1'b1;
      end
    end
  end

  assign alu_ready = w_gnt_alu;
  assign mem_ready = w_gnt_mem;

  assign w_wrd   = w_gnt_mem ? mem_rd   : alu_rd;
  assign w_wdata = w_gnt_mem ? mem_data : alu_data;
  // A grant to x0 consumes the request but never reaches the register file.
  assign w_wr    = (w_gnt_alu || w_gnt_mem) && (w_wrd != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= w_wr;
      if (w_wr) begin
        rf_waddr <= w_wrd;
        rf_wdata <= w_wdata;
      end
    end
  end

  // Clear first, then set, so a same-cycle set on the register being written
  // leaves it pending for the new producer.
  always_comb begin
    w_pending_nxt = r_pending;
    if (rf_we) begin
      w_pending_nxt[rf_waddr] = 1'b0;
    end
    if (sb_set && (sb_set_rd != '0)) begin
      w_pending_nxt[sb_set_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // The register being written this cycle is bypassed by the register file,
  // so it already reads as not busy.
  function automatic logic f_busy(input logic [NREG-1:0] pend,
                                  input logic            we,
                                  input logic [AW-1:0]   waddr,
                                  input logic [AW-1:0]   q);
    f_busy = pend[q] && !(we && (waddr == q)) && (q != '0);
  endfunction

  assign rs1_busy = f_busy(r_pending, rf_we, rf_waddr, rs1_q);
  assign rs2_busy = f_busy(r_pending, rf_we, rf_waddr, rs2_q);
  assign rd_busy  = f_busy(r_pending, rf_we, rf_waddr, rd_q);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
`timescale 1ns/1ps
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd;
  logic [63:0] alu_data, mem_data;
  logic        sb_set;
  logic [4:0]  sb_set_rd;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic        rs1_busy, rs2_busy, rd_busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic [4:0]  last_rd;
  logic [63:0] last_data;

  rf_wb_arbiter #(.XLEN(64), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .sb_set(sb_set), .sb_set_rd(sb_set_rd),
    .rs1_q(rs1_q), .rs2_q(rs2_q), .rd_q(rd_q),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write presented on the register-file port is popped
  // against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got waddr=%0d wdata=0x%0h want no write (t=%0t)",
                 rf_waddr, rf_wdata, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb_waddr", {59'd0, rf_waddr}, {59'd0, e.rd});
        chk("wb_wdata", rf_wdata, e.data);
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    sb_set    = 1'b0;
  endtask

  task automatic set_sb(input logic [4:0] r);
    @(negedge clk);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    sb_set    = 1'b1;
    sb_set_rd = r;
  endtask

  // Present one request cycle and check the grant against the hand-computed
  // expectation; expected writes go to the scoreboard.
  task automatic req(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                     input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                     input logic ea, input logic em, input string nm);
    @(negedge clk);
    sb_set    = 1'b0;
    alu_valid = av;  alu_rd = ard;  alu_data = ad;
    mem_valid = mv;  mem_rd = mrd;  mem_data = md;
    #1;
    chk({nm, "_alu_ready"}, {63'd0, alu_ready}, {63'd0, ea});
    chk({nm, "_mem_ready"}, {63'd0, mem_ready}, {63'd0, em});
    if (ea && ard != 5'd0) exp_q.push_back('{ard, ad});
    if (em && mrd != 5'd0) exp_q.push_back('{mrd, md});
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h22;
    sb_set = 1'b0; sb_set_rd = 5'd0;
    rs1_q = 5'd0; rs2_q = 5'd0; rd_q = 5'd0;
    last_rd = 5'd0; last_data = 64'd0;

    // Reset held with both requesters valid.
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
      chk("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("rst_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("rst_rf_wdata", rf_wdata, 64'd0);
    for (int q = 0; q < 32; q++) begin
      rs1_q = q[4:0];
      #0.1;
      chk("rst_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    end

    // Single write with scoreboard set then clear.
    set_sb(5'd5);
    idle();
    rs1_q = 5'd5;
    #1;
    chk("sw_busy_before", {63'd0, rs1_busy}, 64'd1);
    req(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, "sw");
    idle();
    #1;
    chk("sw_busy_bypass", {63'd0, rs1_busy}, 64'd0);
    idle();
    #1;
    chk("sw_busy_after", {63'd0, rs1_busy}, 64'd0);
    chk("sw_we_after", {63'd0, rf_we}, 64'd0);

    // Conflict: three cycles with both valid, then the leftover alu request.
`ifdef WB_RR_EN
    req(1'b1, 5'd10, 64'hA0A0, 1'b1, 5'd11, 64'hB1B1, 1'b0, 1'b1, "cf1");
    req(1'b1, 5'd10, 64'hA0A0, 1'b1, 5'd12, 64'hC2C2, 1'b1, 1'b0, "cf2");
    req(1'b1, 5'd14, 64'hD4D4, 1'b1, 5'd12, 64'hC2C2, 1'b0, 1'b1, "cf3");
    req(1'b1, 5'd14, 64'hD4D4, 1'b0, 5'd0,  64'd0,    1'b1, 1'b0, "cf4");
    last_rd = 5'd14; last_data = 64'hD4D4;
`else
    req(1'b1, 5'd10, 64'hA0A0, 1'b1, 5'd11, 64'hB1B1, 1'b0, 1'b1, "cf1");
    req(1'b1, 5'd10, 64'hA0A0, 1'b1, 5'd12, 64'hC2C2, 1'b0, 1'b1, "cf2");
    req(1'b1, 5'd10, 64'hA0A0, 1'b1, 5'd13, 64'hE3E3, 1'b0, 1'b1, "cf3");
    req(1'b1, 5'd10, 64'hA0A0, 1'b0, 5'd0,  64'd0,    1'b1, 1'b0, "cf4");
    last_rd = 5'd10; last_data = 64'hA0A0;
`endif
    idle();
    idle();
    #1;
    chk("hold_rf_we", {63'd0, rf_we}, 64'd0);
    chk("hold_waddr", {59'd0, rf_waddr}, {59'd0, last_rd});
    chk("hold_wdata", rf_wdata, last_data);

    // Write to x0 is consumed without a register-file write.
    rs1_q = 5'd0;
    req(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFFFF, 1'b0, 1'b1, "x0");
    chk("x0_busy_grant", {63'd0, rs1_busy}, 64'd0);
    idle();
    #1;
    chk("x0_rf_we", {63'd0, rf_we}, 64'd0);
    chk("x0_busy_next", {63'd0, rs1_busy}, 64'd0);

    // Set and clear of the same register in one cycle: set wins.
    rd_q = 5'd7;
    set_sb(5'd7);
    req(1'b1, 5'd7, 64'h7777, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, "sc");
    set_sb(5'd7);
    #1;
    chk("sc_busy_bypass", {63'd0, rd_busy}, 64'd0);
    idle();
    #1;
    chk("sc_busy_set_wins", {63'd0, rd_busy}, 64'd1);

    // Reset mid-operation with pending {3,9} and an alu grant in flight.
    set_sb(5'd3);
    set_sb(5'd9);
    idle();
    rs1_q = 5'd3; rs2_q = 5'd9;
    #1;
    chk("mr_busy3_pre", {63'd0, rs1_busy}, 64'd1);
    chk("mr_busy9_pre", {63'd0, rs2_busy}, 64'd1);
    req(1'b1, 5'd3, 64'h3333, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, "mr");
    void'(exp_q.pop_back());
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_alu_ready_rst", {63'd0, alu_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    alu_valid = 1'b0;
    #1;
    chk("mr_rf_we", {63'd0, rf_we}, 64'd0);
    chk("mr_busy3", {63'd0, rs1_busy}, 64'd0);
    chk("mr_busy9", {63'd0, rs2_busy}, 64'd0);
    chk("mr_busy7", {63'd0, rd_busy}, 64'd0);

    // First conflict after reset goes to mem in either arbitration mode.
    req(1'b1, 5'd20, 64'h2020, 1'b1, 5'd21, 64'h2121, 1'b0, 1'b1, "pr1");
    req(1'b1, 5'd20, 64'h2020, 1'b0, 5'd0,  64'd0,    1'b1, 1'b0, "pr2");
    idle();
    idle();
    idle();
    chk("sb_drained", exp_q.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
